bus_arb8_rr: RTL and testbench

//  Round-robin arbiter/sequencer that shares a 32-bit 8:1 mux32_8way datapath among 8 requesters.
//  It produces the registered 3-bit mux select, a one-hot grant and a valid/ready handshake toward the single consumer.

---
 rtl/bus_arb8_rr.sv | 118 +++++++++++
 tb/tb_bus_arb8_rr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb8_rr.sv
// Round-robin arbiter for 8 requesters sharing one 32-bit 8:1 mux, with locked bursts
// and a valid/ready handshake toward a single consumer.

module mux32_8way #(
    parameter int DATA_W = 32
) (
    input  logic [7:0][DATA_W-1:0] d,
    input  logic [2:0]             sel,
    output logic [DATA_W-1:0]      y
);
    assign y = d[sel];
endmodule

module bus_arb8_rr #(
    parameter int         DATA_W    = 32,
    parameter int         NREQ      = 8,
    parameter logic [2:0] RESET_PTR = 3'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            lock,
    input  logic [NREQ-1:0][DATA_W-1:0] data_in,
    input  logic                       out_ready,
    output logic [NREQ-1:0]            grant,
    output logic [NREQ-1:0]            ack,
    output logic [2:0]                 sel,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          data_out
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      sel_q, sel_d;
    logic [2:0]      prio_ptr_q, prio_ptr_d;

    logic            owner_req;
    logic            beat_ack;
    logic            release_own;
    logic [2:0]      release_ptr;
    logic [3:0]      pick_idle;
    logic [3:0]      pick_rel;

    // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... modulo 8.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign owner_req   = req[sel_q];
    assign out_valid   = (state_q == ST_OWN) && owner_req;
    assign beat_ack    = out_valid && out_ready;
    assign ack         = grant_q & {NREQ{beat_ack}};
    assign grant       = grant_q;
    assign sel         = sel_q;
    assign release_ptr = sel_q + 3'd1;
    // Owner leaves on an unlocked accepted beat or when it drops req without an ack.
    assign release_own = (state_q == ST_OWN) && (!owner_req || (beat_ack && !lock[sel_q]));
    assign pick_idle   = rr_pick(req, prio_ptr_q);
    // Masking the owner keeps it from winning twice in a row without lock.
    assign pick_rel    = rr_pick(req & ~grant_q, release_ptr);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        prio_ptr_d = prio_ptr_q;
        if (state_q == ST_IDLE) begin
            if (pick_idle[3]) begin
                state_d = ST_OWN;
                sel_d   = pick_idle[2:0];
                grant_d = onehot(pick_idle[2:0]);
            end
        end else if (release_own) begin
            prio_ptr_d = release_ptr;
            if (pick_rel[3]) begin
                sel_d   = pick_rel[2:0];
                grant_d = onehot(pick_rel[2:0]);
            end else begin
                state_d = ST_IDLE;
                sel_d   = 3'd0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= 3'd0;
            prio_ptr_q <= RESET_PTR;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            prio_ptr_q <= prio_ptr_d;
        end
    end

    mux32_8way #(.DATA_W(DATA_W)) u_mux (
        .d   (data_in),
        .sel (sel_q),
        .y   (data_out)
    );
endmodule

// File: tb/tb_bus_arb8_rr.sv
// Directed bench for bus_arb8_rr: expected accepted beats are queued by the stimulus
// and popped by a monitor on every beat the arbiter hands to the consumer.

module tb_bus_arb8_rr;
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [7:0]        req = '0;
    logic [7:0]        lock = '0;
    logic [7:0][31:0]  data_in = '0;
    logic              out_ready = 1'b0;
    logic [7:0]        grant;
    logic [7:0]        ack;
    logic [2:0]        sel;
    logic              out_valid;
    logic [31:0]       data_out;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t mon_e;
    int        checks = 0;
    int        fails = 0;
    logic [7:0] cur_tag = 8'h00;

    bus_arb8_rr #(.DATA_W(32), .NREQ(8), .RESET_PTR(3'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant     (grant),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(input int idx, input logic [7:0] tag);
        return {tag, 8'(8'h10 * idx), ~tag, 8'(idx)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tag(input logic [7:0] tag);
        cur_tag = tag;
        for (int i = 0; i < 8; i++) data_in[i] = exp_data(i, tag);
    endtask

    task automatic push_exp(input int idx);
        sb_entry_t e;
        e.idx  = 3'(idx);
        e.data = exp_data(idx, cur_tag);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        req = '0;
        lock = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Waits for n accepted beats, then returns just after the edge that consumes the last one.
    task automatic wait_acks(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ack != 8'h00) seen++;
        end
        checks++;
        if (seen < n) begin
            fails++;
            $display("FAIL %s_timeout acks=%0d expected=%0d", name, seen, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drained(input string name);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat actual_grant=%h expected=none at %0t", grant, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("beat_sel",   32'(sel),   32'(mon_e.idx));
                check("beat_grant", 32'(grant), 32'(8'b1 << mon_e.idx));
                check("beat_ack",   32'(ack),   32'(8'b1 << mon_e.idx));
                check("beat_data",  data_out,   mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        set_tag(8'h11);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_sel", 32'(sel), 32'd0);
        end

        // All requesting, no lock: 0..7 then wrap to 0
        do_reset();
        set_tag(8'h22);
        for (int i = 0; i < 8; i++) push_exp(i);
        push_exp(0);
        req = 8'hFF;
        out_ready = 1'b1;
        wait_acks(9, "rr_all");
        req = 8'h00;
        sb_drained("rr_all");

        // Stall on owner 0 for 3 cycles, then accept; next owner is 7
        do_reset();
        set_tag(8'h33);
        push_exp(0);
        push_exp(7);
        req = 8'h81;
        out_ready = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("stall_grant", 32'(grant), 32'h01);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ack", 32'(ack), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_acks(2, "stall");
        req = 8'h00;
        sb_drained("stall");

        // Locked burst of 4 beats on requester 2, then requester 5
        do_reset();
        set_tag(8'h44);
        for (int i = 0; i < 4; i++) push_exp(2);
        push_exp(5);
        req = 8'h24;
        lock = 8'h04;
        out_ready = 1'b1;
        wait_acks(3, "lock_a");
        lock = 8'h00;
        wait_acks(2, "lock_b");
        req = 8'h00;
        sb_drained("lock");

        // Owner 3 drops req without an ack; re-arbitration starts from 4
        do_reset();
        set_tag(8'h55);
        req = 8'h18;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_grant", 32'(grant), 32'h08);
        @(posedge clk);
        #1;
        req = 8'h11;
        out_ready = 1'b1;
        @(negedge clk);
        check("drop_valid", 32'(out_valid), 32'd0);
        check("drop_ack", 32'(ack), 32'd0);
        push_exp(4);
        wait_acks(1, "drop");
        req = 8'h00;
        sb_drained("drop");

        // Async reset during a stall of owner 6
        do_reset();
        set_tag(8'h66);
        req = 8'h40;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_grant", 32'(grant), 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_grant", 32'(grant), 32'd0);
        push_exp(6);
        wait_acks(1, "rst_mid");
        req = 8'h00;
        sb_drained("rst_mid");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
